// File: rtl/fp_conv_pkg.sv
// Shared definitions for the decimal <-> binary32 conversion blocks.
// Contents: FSM state enum, IEEE-754 binary32 constants, the Q32 reciprocal of ten,
//           and default input widths for the decimal significand and exponent.
package fp_conv_pkg;

  localparam int MAN_W_DEF = 25;
  localparam int EXP_W_DEF = 7;

  localparam int          FP_BIAS    = 127;
  // ceil(2^35 / 10): multiplying by it and taking the top 32 bits of the
  // 64-bit product approximates a divide by ten on a normalised mantissa.
  localparam logic [31:0] TENTH_Q    = 32'hCCCCCCCD;
  localparam logic [7:0]  FP_INF_EXP = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    SCALE,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter.
// Ports: din (32-bit word), cnt (number of zeros above the highest set bit; 32 when din==0).
module lzc32 (
  input  logic [31:0] din,
  output logic [5:0]  cnt
);

  // Scan upward so the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (din[i]) cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/dec2bi_seq.sv
// Sequential decimal (significand * 10^exp) to IEEE-754 binary32 converter.
// Ports: clk/rst_n (sync, active low); start/sign_in/nguyen/luythua request;
//        busy, done pulse, result word, overflow (saturate to inf), underflow (flush to zero).
module dec2bi_seq
  import fp_conv_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign_in,
  input  logic [MAN_W-1:0] nguyen,
  input  logic [EXP_W-1:0] luythua,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic             overflow,
  output logic             underflow
);

  state_t state, state_nx;

  logic             sign_q;
  logic             dir_q;     // 1: divide by ten each step
  logic             zero_q;
  logic             sticky_q;
  logic [MAN_W-1:0] nguyen_q;
  logic [EXP_W-1:0] k_q;       // remaining scale steps
  logic [31:0]      m_q;       // working mantissa, value = m_q * 2^(e_q-31)
  logic signed [9:0] e_q;

  // Normalisation
  logic [31:0] m_raw;
  logic [5:0]  lz;
  assign m_raw = 32'(nguyen_q);

  lzc32 u_lzc (
    .din (m_raw),
    .cnt (lz)
  );

  // |luythua|; -2^(EXP_W-1) still fits as an unsigned EXP_W-bit value.
  logic [EXP_W-1:0] k_in;
  assign k_in = luythua[EXP_W-1] ? ((~luythua) + EXP_W'(1)) : luythua;

  // Scaling products
  logic [35:0] p_mul;
  logic [63:0] p_div;
  assign p_mul = 36'(m_q) * 36'd10;
  assign p_div = 64'(m_q) * 64'(TENTH_Q);

  // Rounding to 24-bit significand, nearest-even
  logic [23:0]        s_pre;
  logic               inc;
  logic [24:0]        s_sum;
  logic [23:0]        s_fin;
  logic signed [9:0]  e_fin;
  logic signed [10:0] b_exp;

  always_comb begin
    s_pre = m_q[31:8];
    inc   = m_q[7] & ((|m_q[6:0]) | sticky_q | s_pre[0]);
    s_sum = {1'b0, s_pre} + {24'd0, inc};
    if (s_sum[24]) begin
      s_fin = 24'h800000;
      e_fin = e_q + 10'sd1;
    end else begin
      s_fin = s_sum[23:0];
      e_fin = e_q;
    end
    b_exp = 11'(e_fin) + 11'(FP_BIAS);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = NORM;
      NORM: begin
        busy = 1'b1;
        if (nguyen_q == '0 || k_q == '0) state_nx = ROUND;
        else                             state_nx = SCALE;
      end
      SCALE: begin
        busy = 1'b1;
        if (k_q == EXP_W'(1)) state_nx = ROUND;
      end
      ROUND: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q    <= 1'b0;
      dir_q     <= 1'b0;
      zero_q    <= 1'b0;
      sticky_q  <= 1'b0;
      nguyen_q  <= '0;
      k_q       <= '0;
      m_q       <= '0;
      e_q       <= '0;
      result    <= 32'h0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_q    <= sign_in;
            nguyen_q  <= nguyen;
            k_q       <= k_in;
            dir_q     <= luythua[EXP_W-1];
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
        end
        NORM: begin
          m_q      <= m_raw << lz;
          e_q      <= 10'sd31 - $signed({4'b0, lz});
          sticky_q <= 1'b0;
          zero_q   <= (nguyen_q == '0);
        end
        SCALE: begin
          k_q <= k_q - EXP_W'(1);
          if (!dir_q) begin
            // x10 grows the value by 3 or 4 binary places
            if (p_mul[35]) begin
              m_q      <= p_mul[35:4];
              e_q      <= e_q + 10'sd4;
              sticky_q <= sticky_q | (|p_mul[3:0]);
            end else begin
              m_q      <= p_mul[34:3];
              e_q      <= e_q + 10'sd3;
              sticky_q <= sticky_q | (|p_mul[2:0]);
            end
          end else begin
            // TENTH_Q carries an implicit 2^-35, hence the -3/-4 exponent step
            if (p_div[63]) begin
              m_q      <= p_div[63:32];
              e_q      <= e_q - 10'sd3;
              sticky_q <= sticky_q | (|p_div[31:0]);
            end else begin
              m_q      <= p_div[62:31];
              e_q      <= e_q - 10'sd4;
              sticky_q <= sticky_q | (|p_div[30:0]);
            end
          end
        end
        ROUND: begin
          if (zero_q) begin
            result <= {sign_q, 31'b0};
          end else if (b_exp >= 11'sd255) begin
            result   <= {sign_q, FP_INF_EXP, 23'b0};
            overflow <= 1'b1;
          end else if (b_exp <= 11'sd0) begin
            result    <= {sign_q, 31'b0};
            underflow <= 1'b1;
          end else begin
            result <= {sign_q, b_exp[7:0], s_fin[22:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dec2bi_seq.md
Name: dec2bi_seq

Overview:
Sequential decimal-to-IEEE-754 single-precision converter. It is the inverse of the float-to-decimal path. It accepts a signed decimal value as an integer significand and a signed power-of-ten exponent, and produces a 32-bit binary32 word. It scales iteratively, one power of ten per clock, over a 32-bit working mantissa, then rounds to nearest-even. It sits in the Bi2Dec/Dec2Bi conversion area and feeds the add_sub/mult float datapath.

Parameters:
EXP_W, 7, width of the signed decimal exponent input (two's complement; covers -64..+63).
MAN_W, 25, width of the unsigned decimal significand input.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous reset, active low.
start  in  1  request; sampled only in IDLE.
sign_in  in  1  sign of the decimal value.
nguyen  in  MAN_W  unsigned decimal significand (integer).
luythua  in  EXP_W  signed power-of-ten exponent; value = (-1)^sign * nguyen * 10^luythua.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse; result and flags are valid that cycle and held afterwards.
result  out  32  binary32 result.
overflow  out  1  result saturated to infinity.
underflow  out  1  result flushed to signed zero (nonzero input only).

Behaviour:
- Reset (rst_n=0 at an edge): state goes to IDLE; busy, done, overflow and underflow are 0; result is 32'h0. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, NORM, SCALE, ROUND, DONE.
- IDLE:
  - On start=1, capture sign_in, nguyen and luythua.
  - Set k=|luythua| and dir=(luythua<0).
  - Go to NORM.
  - start outside IDLE is ignored.
- NORM (1 cycle):
  - M = nguyen zero-extended to 32 bits, left-shifted by lzc(M) so that M[31]=1. E = 31 - lzc. Value is M*2^(E-31).
  - sticky=0.
  - If nguyen==0, set zero flag and go to ROUND. Else go to SCALE if k!=0, otherwise ROUND.
- SCALE (k cycles, one step per cycle, k decrements):
  - Multiply by 10 (dir=0):
    - P = M*10, 36 bits.
    - If P[35]: M=P[35:4], E+=4, sticky|=|P[3:0].
    - Else: M=P[34:3], E+=3, sticky|=|P[2:0].
  - Divide by 10 (dir=1):
    - P = M*32'hCCCCCCCD, 64 bits.
    - If P[63]: M=P[63:32], E-=3, sticky|=|P[31:0].
    - Else: M=P[62:31], E-=4, sticky|=|P[30:0].
  - E is signed 10 bits and never wraps in range. The exit condition is k==1 at step end; then go to ROUND.
- ROUND (1 cycle):
  - Significand S=M[31:8], guard g=M[7], st=|M[6:0] | sticky.
  - Round to nearest even: increment S if g & (st | S[0]). If the increment carries out, S=24'h800000 and E+=1.
  - Biased exponent B=E+127.
  - zero flag: result={sign,31'b0}.
  - Else if B>=255: result={sign,8'hFF,23'b0}, overflow=1.
  - Else if B<=0: result={sign,31'b0}, underflow=1 (no subnormals).
  - Else: result={sign,B[7:0],S[22:0]}.
- DONE (1 cycle): done=1, busy=0 that cycle, then return to IDLE. result and flags hold until the next accepted start; flags clear on acceptance.
- Latency: start accepted at edge T gives done=1 in cycle T+3+k. nguyen=0 is always T+3.
- Scaling is deterministic. The bench model must replicate the 0xCCCCCCCD reciprocal and sticky rules bit-exactly, not an ideal decimal conversion.

Decomposition:
- Shared package fp_conv_pkg holds:
  - the state enum;
  - the constants FP_BIAS=127, TENTH_Q=32'hCCCCCCCD, FP_INF_EXP=8'hFF;
  - MAN_W/EXP_W defaults.
- One sub-module: lzc32 (combinational 32-bit leading-zero count, 6-bit output), used in NORM.
- The multipliers are inline.

Test Plan:
- nguyen=1, luythua=0, sign=0 → result 32'h3F800000 at T+3, flags 0.
- nguyen=15, luythua=-1, sign=1 → one divide step; M=0xC0000000, E=0, sticky=1 → result 32'hBFC00000 at T+4.
- nguyen=125, luythua=+1 → 1250 exact → result 32'h449C4000 at T+4.
- nguyen=1, luythua=+39 → overflow=1, result 32'h7F800000 at T+42. Also nguyen=1, luythua=-46, sign=1 → underflow=1, result 32'h80000000 at T+49.
- nguyen=0, luythua=+20, sign=1 → result 32'h80000000 at T+3, no flags, no SCALE cycles.
- Start pulsed while busy → ignored, single done. rst_n=0 during SCALE → next cycle busy=0, done never pulses, result=0; a new start then completes normally.
